alu_issue_ctrl: RTL and testbench

- Upstream issue/writeback stage for the team's 4-bit combinational ALU (ports a, b, s in; out, cout back).
- Holds a small operand register file and accepts operation requests over a valid/ready handshake.
- Drives registered operands and opcode into the ALU, captures the result and carry, writes the result back to the destination register, and presents a response over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 109 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state type and width defaults for the ALU issue block.
package alu_pkg;
  localparam int DW_DEF = 4;
  localparam int NREG_DEF = 4;
  localparam int AW_DEF = 2;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100;
  localparam logic [2:0] OP_SHL2A = 3'b101;
  localparam logic [2:0] OP_SHR1B = 3'b110;
  localparam logic [2:0] OP_SHL1A = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW operand storage, two read ports plus debug read,
// writeback taking priority over an external load to the same register.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ext_en,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_data
);
  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && wb_addr == AW'(i)) regs_q[i] <= wb_data;
        else if (ext_en && ext_addr == AW'(i)) regs_q[i] <= ext_data;
      end
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file operands to a combinational ALU and
// writes the result back, with valid/ready request and response handshakes.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry
);
  state_e state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, rd1, rd2;
  logic [2:0] s_q, s_d;
  logic [AW-1:0] rd_q, rd_d;
  logic rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, wb_en;

  alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(req_rs1), .ra2(req_rs2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_en(wb_en), .wb_addr(rd_q), .wb_data(alu_out),
    .ext_en(wr_en), .ext_addr(wr_addr), .ext_data(wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      rd_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      rd_q <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    rd_d = rd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    wb_en = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        a_d = rd1;
        b_d = rd2;
        s_d = req_op;
        rd_d = req_rd;
        state_d = EXEC;
      end
      EXEC: begin
        wb_en = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_data_d = alu_out;
        rsp_carry_d = (s_q == OP_ADD) ? alu_cout : 1'b0;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_s = s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors and corner sequences for alu_issue_ctrl
// driven by a behavioural 4-bit ALU.
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  localparam int DW = 4;
  localparam int AW = 2;

  logic clk = 1'b0, rst_n = 1'b1;
  logic req_valid = 1'b0, req_ready, wr_en = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_carry, alu_cout;
  logic [2:0] req_op = '0, alu_s;
  logic [AW-1:0] req_rd = '0, req_rs1 = '0, req_rs2 = '0, wr_addr = '0, dbg_addr = '0;
  logic [DW-1:0] wr_data = '0, dbg_data, alu_a, alu_b, alu_out, rsp_data;
  logic [4:0] alu_r;
  int checks = 0, failures = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b, data;
    logic carry;
  } vec_t;
  vec_t tv[11];

  alu_issue_ctrl #(.DW(DW), .NREG(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; the carry bit is deliberately live for every opcode.
  always_comb begin
    case (alu_s)
      OP_ADD:   alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:   alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:   alu_r = {1'b0, alu_a & alu_b};
      OP_XOR:   alu_r = {1'b0, alu_a ^ alu_b};
      OP_OR:    alu_r = {1'b0, alu_a | alu_b};
      OP_SHL2A: alu_r = {alu_a[2], alu_a[1:0], 2'b00};
      OP_SHR1B: alu_r = {1'b1, 1'b0, alu_b[3:1]};
      default:  alu_r = {alu_a, 1'b0};
    endcase
  end
  assign alu_out = alu_r[3:0];
  assign alu_cout = alu_r[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input string nm, input logic [AW-1:0] addr, input int exp);
    dbg_addr = addr;
    #1;
    chk(nm, int'(dbg_data), exp);
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs1, rs2);
    req_valid = 1'b1;
    req_op = op;
    req_rd = rd;
    req_rs1 = rs1;
    req_rs2 = rs2;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    tv[0]  = '{OP_ADD,   4'd9,  4'd8,  4'd1,  1'b1};
    tv[1]  = '{OP_ADD,   4'd3,  4'd4,  4'd7,  1'b0};
    tv[2]  = '{OP_ADD,   4'd15, 4'd15, 4'd14, 1'b1};
    tv[3]  = '{OP_SUB,   4'd9,  4'd8,  4'd1,  1'b0};
    tv[4]  = '{OP_SUB,   4'd3,  4'd5,  4'd14, 1'b0};
    tv[5]  = '{OP_AND,   4'd12, 4'd10, 4'd8,  1'b0};
    tv[6]  = '{OP_XOR,   4'd12, 4'd10, 4'd6,  1'b0};
    tv[7]  = '{OP_OR,    4'd12, 4'd10, 4'd14, 1'b0};
    tv[8]  = '{OP_SHL2A, 4'd3,  4'd9,  4'd12, 1'b0};
    tv[9]  = '{OP_SHR1B, 4'd7,  4'd10, 4'd5,  1'b0};
    tv[10] = '{OP_SHL1A, 4'd9,  4'd1,  4'd2,  1'b0};

    // Asynchronous reset, checked mid-cycle before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_carry", int'(rsp_carry), 0);
    chk("rst_alu_abs", int'({alu_a, alu_b, alu_s}), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("rst_req_ready", int'(req_ready), 1);
    for (int i = 0; i < 4; i++) dbg($sformatf("rst_dbg_r%0d", i), AW'(i), 0);

    for (int i = 0; i < 11; i++) begin
      load(2'd1, tv[i].a);
      load(2'd2, tv[i].b);
      chk($sformatf("v%0d_ready", i), int'(req_ready), 1);
      issue(tv[i].op, 2'd3, 2'd1, 2'd2);
      chk($sformatf("v%0d_alu_a", i), int'(alu_a), int'(tv[i].a));
      chk($sformatf("v%0d_alu_b", i), int'(alu_b), int'(tv[i].b));
      chk($sformatf("v%0d_alu_s", i), int'(alu_s), int'(tv[i].op));
      chk($sformatf("v%0d_exec_busy", i), int'({req_ready, rsp_valid}), 0);
      tick();
      chk($sformatf("v%0d_rsp_valid", i), int'(rsp_valid), 1);
      chk($sformatf("v%0d_rsp_data", i), int'(rsp_data), int'(tv[i].data));
      chk($sformatf("v%0d_rsp_carry", i), int'(rsp_carry), int'(tv[i].carry));
      dbg($sformatf("v%0d_wb_r3", i), 2'd3, int'(tv[i].data));
      tick();
      chk($sformatf("v%0d_idle", i), int'({req_ready, rsp_valid}), 2);
    end

    // Backpressure: response held, new requests refused while in RESP.
    load(2'd1, 4'd12);
    load(2'd2, 4'd10);
    rsp_ready = 1'b0;
    issue(OP_AND, 2'd3, 2'd1, 2'd2);
    tick();
    req_valid = 1'b1;
    req_op = OP_XOR;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), int'(rsp_valid), 1);
      chk($sformatf("bp%0d_data", k), int'(rsp_data), 8);
      chk($sformatf("bp%0d_ready", k), int'(req_ready), 0);
      chk($sformatf("bp%0d_alu_s", k), int'(alu_s), int'(OP_AND));
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", int'({req_ready, rsp_valid}), 2);

    // Destination equals a source.
    load(2'd1, 4'd9);
    load(2'd2, 4'd8);
    issue(OP_SUB, 2'd1, 2'd1, 2'd2);
    tick();
    chk("rdrs_data", int'(rsp_data), 1);
    chk("rdrs_carry", int'(rsp_carry), 0);
    dbg("rdrs_r1", 2'd1, 1);
    tick();
    issue(OP_SHL1A, 2'd0, 2'd1, 2'd1);
    tick();
    chk("rdrs_shl_data", int'(rsp_data), 2);
    dbg("rdrs_r0", 2'd0, 2);
    tick();

    // Writeback beats an external write to the same register.
    load(2'd1, 4'd1);
    load(2'd2, 4'd3);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2);
    wr_en = 1'b1;
    wr_addr = 2'd3;
    wr_data = 4'd15;
    tick();
    wr_en = 1'b0;
    chk("coll_rsp", int'(rsp_data), 4);
    dbg("coll_r3_wb", 2'd3, 4);
    tick();
    load(2'd3, 4'd15);
    dbg("coll_r3_idle", 2'd3, 15);

    // Operand read at accept sees pre-edge contents (no write bypass).
    load(2'd1, 4'd5);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 4'd7;
    issue(OP_ADD, 2'd0, 2'd1, 2'd1);
    wr_en = 1'b0;
    chk("nobyp_alu_a", int'(alu_a), 5);
    tick();
    chk("nobyp_rsp", int'(rsp_data), 10);
    dbg("nobyp_r1", 2'd1, 7);
    tick();

    // Reset during EXEC aborts without writeback.
    load(2'd1, 4'd2);
    load(2'd2, 4'd3);
    issue(OP_ADD, 2'd2, 2'd1, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rexec_valid", int'(rsp_valid), 0);
    chk("rexec_alu_a", int'(alu_a), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rexec_after_valid", int'(rsp_valid), 0);
    chk("rexec_ready", int'(req_ready), 1);
    dbg("rexec_r2", 2'd2, 0);
    load(2'd1, 4'd2);
    load(2'd2, 4'd3);
    issue(OP_ADD, 2'd2, 2'd1, 2'd2);
    tick();
    chk("rexec_next_valid", int'(rsp_valid), 1);
    chk("rexec_next_data", int'(rsp_data), 5);
    dbg("rexec_next_r2", 2'd2, 5);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
